rsa_modexp_ctrl: RTL and testbench

Sequencer for one RSA modular exponentiation, crypto = msg^key mod modulus. It drives the two-power-mod unit once to obtain R^2 mod N, where R = 2^KEY_WIDTH. It then drives the shared Montgomery multiplier through a right-to-left square-and-multiply loop over the key bits. It sits between the RSA top-level request/response ports and the two arithmetic units. It holds all operand and result registers and contains no arithmetic beyond a bit counter.

---
 rtl/rsa_modexp_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_ctrl.sv
// ============================================================================
// rsa_modexp_ctrl : RSA modexp sequencer (R^2 via two-power-mod, then R-to-L
//                   square-and-multiply on a shared Montgomery multiplier)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module rsa_modexp_ctrl #(
  parameter int KEY_WIDTH   = 256,
  parameter int POWER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [KEY_WIDTH-1:0]   i_msg,
  input  logic [KEY_WIDTH-1:0]   i_key,
  input  logic [KEY_WIDTH-1:0]   i_modulus,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [KEY_WIDTH-1:0]   o_crypto,
  output logic                   tpm_valid,
  input  logic                   tpm_ready,
  output logic [KEY_WIDTH-1:0]   tpm_modulus,
  output logic [POWER_WIDTH-1:0] tpm_power,
  input  logic                   tpm_out_valid,
  output logic                   tpm_out_ready,
  input  logic [KEY_WIDTH-1:0]   tpm_out,
  output logic                   mont_valid,
  input  logic                   mont_ready,
  output logic [KEY_WIDTH-1:0]   mont_a,
  output logic [KEY_WIDTH-1:0]   mont_b,
  output logic [KEY_WIDTH-1:0]   mont_modulus,
  input  logic                   mont_out_valid,
  output logic                   mont_out_ready,
  input  logic [KEY_WIDTH-1:0]   mont_out
);

  localparam int IDX_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
  localparam logic [IDX_W-1:0]       c_LAST_IDX  = IDX_W'(KEY_WIDTH - 1);
  localparam logic [POWER_WIDTH-1:0] c_TPM_POWER = POWER_WIDTH'(2 * KEY_WIDTH);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_TPM_REQ   = 4'd1;
  localparam logic [3:0] S_TPM_WAIT  = 4'd2;
  localparam logic [3:0] S_CONV_REQ  = 4'd3;
  localparam logic [3:0] S_CONV_WAIT = 4'd4;
  localparam logic [3:0] S_BIT       = 4'd5;
  localparam logic [3:0] S_MUL_REQ   = 4'd6;
  localparam logic [3:0] S_MUL_WAIT  = 4'd7;
  localparam logic [3:0] S_SQR_REQ   = 4'd8;
  localparam logic [3:0] S_SQR_WAIT  = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  logic [3:0]           state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, n_q, msg_q, base_q, crypto_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 w_last;

  assign w_last = (idx_q == c_LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (i_valid)        state_d = S_TPM_REQ;
      S_TPM_REQ:   if (tpm_ready)      state_d = S_TPM_WAIT;
      S_TPM_WAIT:  if (tpm_out_valid)  state_d = S_CONV_REQ;
      S_CONV_REQ:  if (mont_ready)     state_d = S_CONV_WAIT;
      S_CONV_WAIT: if (mont_out_valid) state_d = S_BIT;
      S_BIT: begin
        if (key_q[idx_q]) state_d = S_MUL_REQ;
        else if (w_last)  state_d = S_DONE;
        else              state_d = S_SQR_REQ;
      end
      S_MUL_REQ:   if (mont_ready)     state_d = S_MUL_WAIT;
      // The square after the final bit would be wasted work, so skip it.
      S_MUL_WAIT:  if (mont_out_valid) state_d = w_last ? S_DONE : S_SQR_REQ;
      S_SQR_REQ:   if (mont_ready)     state_d = S_SQR_WAIT;
      S_SQR_WAIT:  if (mont_out_valid) state_d = S_BIT;
      S_DONE:      if (o_ready)        state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    i_ready        = 1'b0;
    o_valid        = 1'b0;
    o_crypto       = '0;
    tpm_valid      = 1'b0;
    tpm_modulus    = '0;
    tpm_power      = '0;
    tpm_out_ready  = 1'b0;
    mont_valid     = 1'b0;
    mont_a         = '0;
    mont_b         = '0;
    mont_modulus   = '0;
    mont_out_ready = 1'b0;
    case (state_q)
      S_IDLE: i_ready = 1'b1;
      S_TPM_REQ: begin
        tpm_valid   = 1'b1;
        tpm_modulus = n_q;
        tpm_power   = c_TPM_POWER;
      end
      S_TPM_WAIT: tpm_out_ready = 1'b1;
      S_CONV_REQ: begin
        mont_valid   = 1'b1;
        mont_a       = msg_q;
        mont_b       = base_q;
        mont_modulus = n_q;
      end
      S_MUL_REQ: begin
        mont_valid   = 1'b1;
        mont_a       = crypto_q;
        mont_b       = base_q;
        mont_modulus = n_q;
      end
      S_SQR_REQ: begin
        mont_valid   = 1'b1;
        mont_a       = base_q;
        mont_b       = base_q;
        mont_modulus = n_q;
      end
      S_CONV_WAIT, S_MUL_WAIT, S_SQR_WAIT: mont_out_ready = 1'b1;
      S_DONE: begin
        o_valid  = 1'b1;
        o_crypto = crypto_q;
      end
      default: ;
    endcase
  end

  // base_q first holds R^2 mod N, then msg in Montgomery form, squared each bit;
  // crypto_q stays in plain form because mont(plain, mont-form) is plain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q    <= '0;
      n_q      <= '0;
      msg_q    <= '0;
      base_q   <= '0;
      crypto_q <= '0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (i_valid) begin
          key_q    <= i_key;
          n_q      <= i_modulus;
          msg_q    <= i_msg;
          crypto_q <= KEY_WIDTH'(1);
          idx_q    <= '0;
        end
        S_TPM_WAIT:  if (tpm_out_valid)  base_q   <= tpm_out;
        S_CONV_WAIT: if (mont_out_valid) base_q   <= mont_out;
        S_MUL_WAIT:  if (mont_out_valid) crypto_q <= mont_out;
        S_SQR_WAIT: if (mont_out_valid) begin
          base_q <= mont_out;
          idx_q  <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rsa_modexp_ctrl.sv
// ============================================================================
// tb_rsa_modexp_ctrl : directed bench for rsa_modexp_ctrl with KEY_WIDTH=8
//                      and behavioural two-power-mod / Montgomery models
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_rsa_modexp_ctrl;

  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_ready;
  logic [KW-1:0] i_msg, i_key, i_modulus;
  logic          o_valid, o_ready;
  logic [KW-1:0] o_crypto;
  logic          tpm_valid, tpm_ready;
  logic [KW-1:0] tpm_modulus;
  logic [31:0]   tpm_power;
  logic          tpm_out_valid, tpm_out_ready;
  logic [KW-1:0] tpm_out;
  logic          mont_valid, mont_ready;
  logic [KW-1:0] mont_a, mont_b, mont_modulus;
  logic          mont_out_valid, mont_out_ready;
  logic [KW-1:0] mont_out;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int mont_xfers = 0;
  int tpm_xfers  = 0;
  int tpm_pow_seen = 0;
  int cur_n = 0;
  bit stall_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rsa_modexp_ctrl #(.KEY_WIDTH(KW), .POWER_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_msg(i_msg), .i_key(i_key), .i_modulus(i_modulus),
    .o_valid(o_valid), .o_ready(o_ready), .o_crypto(o_crypto),
    .tpm_valid(tpm_valid), .tpm_ready(tpm_ready), .tpm_modulus(tpm_modulus), .tpm_power(tpm_power),
    .tpm_out_valid(tpm_out_valid), .tpm_out_ready(tpm_out_ready), .tpm_out(tpm_out),
    .mont_valid(mont_valid), .mont_ready(mont_ready), .mont_a(mont_a), .mont_b(mont_b),
    .mont_modulus(mont_modulus), .mont_out_valid(mont_out_valid),
    .mont_out_ready(mont_out_ready), .mont_out(mont_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a*b*R^-1 mod n with R = 2^KW, found as the unique x with x*R == a*b (mod n)
  function automatic int mont_ref(input int a, input int b, input int n);
    int t;
    t = (a * b) % n;
    for (int x = 0; x < n; x++)
      if (((x << KW) % n) == t) return x;
    return 0;
  endfunction

  function automatic int pow2_ref(input int p, input int n);
    int r;
    r = 1 % n;
    for (int i = 0; i < p; i++) r = (r * 2) % n;
    return r;
  endfunction

  function automatic int modexp_ref(input int m, input int k, input int n);
    int r, b;
    r = 1;
    b = m % n;
    for (int i = 0; i < KW; i++) begin
      if (((k >> i) & 1) == 1) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  // two-power-mod model
  bit tpm_pend, t_req, t_rsp;
  int tpm_cnt, t_res;
  initial begin
    tpm_ready = 1'b0; tpm_out_valid = 1'b0; tpm_out = '0; tpm_pend = 1'b0; tpm_cnt = 0; t_res = 0;
    forever begin
      @(negedge clk);
      t_req = tpm_valid && tpm_ready && !rst;
      t_rsp = tpm_out_valid && tpm_out_ready;
      if (t_req) begin
        tpm_xfers++;
        tpm_pow_seen = int'(tpm_power);
        check("tpm_modulus", 64'(tpm_modulus), 64'(cur_n));
        t_res = pow2_ref(int'(tpm_power), int'(tpm_modulus));
      end
      @(posedge clk);
      #1;
      if (rst) begin
        tpm_ready = 1'b0; tpm_out_valid = 1'b0; tpm_pend = 1'b0;
      end else begin
        if (t_rsp) tpm_out_valid = 1'b0;
        if (t_req) begin
          tpm_pend = 1'b1;
          tpm_cnt  = stall_en ? int'($urandom_range(0, 5)) : 0;
        end
        if (tpm_pend && !tpm_out_valid) begin
          if (tpm_cnt == 0) begin
            tpm_out_valid = 1'b1; tpm_out = KW'(t_res); tpm_pend = 1'b0;
          end else tpm_cnt--;
        end
        tpm_ready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
    end
  end

  // Montgomery model, also watches operand stability while a request stalls
  bit m_pend, m_req, m_rsp, m_held;
  int m_cnt, m_res;
  logic [3*KW-1:0] m_saved;
  initial begin
    mont_ready = 1'b0; mont_out_valid = 1'b0; mont_out = '0;
    m_pend = 1'b0; m_held = 1'b0; m_cnt = 0; m_res = 0; m_saved = '0;
    forever begin
      @(negedge clk);
      m_req = mont_valid && mont_ready && !rst;
      m_rsp = mont_out_valid && mont_out_ready;
      if (mont_valid && !rst) begin
        if (m_held)
          check("mont_operands_stable", 64'({mont_a, mont_b, mont_modulus}), 64'(m_saved));
        m_saved = {mont_a, mont_b, mont_modulus};
        m_held  = !mont_ready;
      end else m_held = 1'b0;
      if (m_req) begin
        mont_xfers++;
        check("mont_modulus", 64'(mont_modulus), 64'(cur_n));
        m_res = mont_ref(int'(mont_a), int'(mont_b), int'(mont_modulus));
      end
      @(posedge clk);
      #1;
      if (rst) begin
        mont_ready = 1'b0; mont_out_valid = 1'b0; m_pend = 1'b0; m_held = 1'b0;
      end else begin
        if (m_rsp) mont_out_valid = 1'b0;
        if (m_req) begin
          m_pend = 1'b1;
          m_cnt  = stall_en ? int'($urandom_range(0, 5)) : 0;
        end
        if (m_pend && !mont_out_valid) begin
          if (m_cnt == 0) begin
            mont_out_valid = 1'b1; mont_out = KW'(m_res); m_pend = 1'b0;
          end else m_cnt--;
        end
        mont_ready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
    end
  end

  task automatic start_req(input string tag, input int m, input int k, input int n);
    bit ok;
    cur_n = n; mont_xfers = 0; tpm_xfers = 0;
    i_msg = KW'(m); i_key = KW'(k); i_modulus = KW'(n); i_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (i_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #2;
    i_valid = 1'b0;
    if (!ok) check({tag, "_accept_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_result(input string tag, input int exp, input int hold);
    bit ok;
    logic [KW-1:0] v;
    if (hold > 0) o_ready = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (o_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check({tag, "_result_timeout"}, 64'(0), 64'(1));
    end else begin
      if (hold > 0) begin
        v = o_crypto;
        repeat (hold) @(negedge clk);
        check({tag, "_hold_valid"}, 64'(o_valid), 64'(1));
        check({tag, "_hold_stable"}, 64'(o_crypto), 64'(v));
        o_ready = 1'b1;
      end
      check({tag, "_result"}, 64'(o_crypto), 64'(exp));
      @(posedge clk);
      #2;
    end
  endtask

  int m, k, n, pc, t_out, t_acc;
  bit ok;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_msg = '0; i_key = '0; i_modulus = '0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_o_valid",        64'(o_valid),        64'(0));
    check("rst_tpm_valid",      64'(tpm_valid),      64'(0));
    check("rst_mont_valid",     64'(mont_valid),     64'(0));
    check("rst_tpm_out_ready",  64'(tpm_out_ready),  64'(0));
    check("rst_mont_out_ready", 64'(mont_out_ready), 64'(0));
    check("rst_o_crypto",       64'(o_crypto),       64'(0));
    rst = 1'b0;
    #1;
    check("rst_i_ready", 64'(i_ready), 64'(1));

    // 5^3 mod 13 = 8 ; 1 + 2 + 7 Montgomery calls, R^2 via 2^16
    start_req("t1", 5, 3, 13);
    wait_result("t1", 8, 0);
    check("t1_mont_count", 64'(mont_xfers), 64'(10));
    check("t1_tpm_count",  64'(tpm_xfers),  64'(1));
    check("t1_tpm_power",  64'(tpm_pow_seen), 64'(16));

    // key 0 gives 1 with only conversion + squares
    start_req("t2", 7, 0, 11);
    wait_result("t2", 1, 0);
    check("t2_mont_count", 64'(mont_xfers), 64'(8));

    // stalls everywhere, 2^255 mod 251 = 32
    stall_en = 1'b1;
    start_req("t3", 2, 255, 251);
    wait_result("t3", 32, 4);
    check("t3_mont_count", 64'(mont_xfers), 64'(16));
    check("t3_tpm_count",  64'(tpm_xfers),  64'(1));
    stall_en = 1'b0;

    // reset while in SQR_WAIT at idx=3 (seventh Montgomery request)
    start_req("t4", 5, 3, 13);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #2;
      if (mont_xfers == 7) begin ok = 1'b1; break; end
    end
    if (!ok) check("t4_reach_timeout", 64'(0), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t4_i_ready",    64'(i_ready),    64'(1));
    check("t4_o_valid",    64'(o_valid),    64'(0));
    check("t4_tpm_valid",  64'(tpm_valid),  64'(0));
    check("t4_mont_valid", 64'(mont_valid), 64'(0));
    @(posedge clk);
    #2;
    start_req("t4b", 5, 3, 13);
    wait_result("t4b", 8, 0);

    // back-to-back: second request waits through DONE, accepted one cycle after
    start_req("t5a", 5, 3, 13);
    i_msg = KW'(2); i_key = KW'(5); i_modulus = KW'(13); i_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (o_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("t5a_result_timeout", 64'(0), 64'(1));
    check("t5a_result", 64'(o_crypto), 64'(8));
    check("t5_no_accept_in_done", 64'(i_ready), 64'(0));
    t_out = cyc;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (i_ready) begin ok = 1'b1; break; end
    end
    t_acc = cyc;
    if (!ok) check("t5b_accept_timeout", 64'(0), 64'(1));
    check("t5_accept_gap", 64'(t_acc - t_out), 64'(1));
    mont_xfers = 0; tpm_xfers = 0;
    @(posedge clk);
    #2;
    i_valid = 1'b0;
    wait_result("t5b", 6, 0);
    check("t5b_mont_count", 64'(mont_xfers), 64'(10));

    // random operands against the software reference, with stalls
    stall_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      n = 2 * int'($urandom_range(1, 127)) + 1;
      m = int'($urandom_range(0, n - 1));
      k = int'($urandom_range(0, 255));
      pc = $countones(k[KW-1:0]);
      start_req("rnd", m, k, n);
      wait_result("rnd", modexp_ref(m, k, n), t % 2);
      check("rnd_mont_count", 64'(mont_xfers), 64'(1 + pc + KW - 1));
    end
    stall_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
